// File: rtl/acc_core_pkg.sv
// Shared definitions for the accumulator micro-sequencer: opcode values and FSM states.
package acc_core_pkg;

    // Opcode values at the default 8-bit opcode width; the core resizes them to OP_W.
    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_LDI  = 8'h01;
    localparam logic [7:0] OP_ADDI = 8'h02;
    localparam logic [7:0] OP_SUBI = 8'h03;
    localparam logic [7:0] OP_OUT  = 8'h04;
    localparam logic [7:0] OP_JMP  = 8'h05;
    localparam logic [7:0] OP_BNZ  = 8'h06;
    localparam logic [7:0] OP_HALT = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_t;

endpackage

// File: rtl/acc_core.sv
// Accumulator micro-sequencer: fetches {op, imm} words over a req/valid handshake,
// executes one instruction per EXEC cycle and drives a registered output port.
module acc_core
    import acc_core_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int OP_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    output logic                   imem_req,
    output logic [ADDR_W-1:0]      imem_addr,
    input  logic [OP_W+DATA_W-1:0] imem_rdata,
    input  logic                   imem_valid,
    output logic [DATA_W-1:0]      out,
    output logic                   out_valid,
    output logic                   halted,
    output logic                   illegal,
    output logic [ADDR_W-1:0]      pc
);

    state_t                   state_reg, state_next;
    logic [OP_W+DATA_W-1:0]   instr_reg;
    logic [ADDR_W-1:0]        pc_reg, pc_next;
    logic [DATA_W-1:0]        acc_reg, acc_next;
    logic [DATA_W-1:0]        out_reg, out_next;
    logic                     out_valid_reg, out_valid_next;
    logic                     illegal_reg, illegal_next;

    logic [OP_W-1:0]          op;
    logic [DATA_W-1:0]        imm;
    logic [ADDR_W-1:0]        target;
    logic [ADDR_W-1:0]        pc_inc;

    assign op     = instr_reg[OP_W+DATA_W-1:DATA_W];
    assign imm    = instr_reg[DATA_W-1:0];
    assign pc_inc = pc_reg + 1'b1;   // natural wrap at 2**ADDR_W

    // Jump target: low imm bits, zero-extended when the immediate is narrower than pc.
    generate
        if (DATA_W >= ADDR_W) begin : g_target_trunc
            assign target = imm[ADDR_W-1:0];
        end else begin : g_target_zext
            assign target = {{(ADDR_W-DATA_W){1'b0}}, imm};
        end
    endgenerate

    // State, program counter, accumulator and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            pc_reg        <= '0;
            acc_reg       <= '0;
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
            illegal_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            acc_reg       <= acc_next;
            out_reg       <= out_next;
            out_valid_reg <= out_valid_next;
            illegal_reg   <= illegal_next;
        end
    end

    // Instruction latch: only a word delivered while fetching is captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_reg <= '0;
        end else if (state_reg == S_FETCH && imem_valid) begin
            instr_reg <= imem_rdata;
        end
    end

    // Next-state sequencing and single-cycle instruction execution.
    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        acc_next       = acc_reg;
        out_next       = out_reg;
        out_valid_next = 1'b0;
        illegal_next   = illegal_reg;
        case (state_reg)
            S_IDLE: begin
                if (run) state_next = S_FETCH;
            end
            S_FETCH: begin
                if (imem_valid) state_next = S_EXEC;
            end
            S_EXEC: begin
                state_next = run ? S_FETCH : S_IDLE;
                if (op == {OP_W{1'b1}}) begin
                    // HALT keeps pc pointing at itself and overrides run.
                    state_next = S_HALT;
                end else begin
                    pc_next = pc_inc;
                    case (op)
                        OP_W'(OP_NOP):  ;
                        OP_W'(OP_LDI):  acc_next = imm;
                        OP_W'(OP_ADDI): acc_next = acc_reg + imm;
                        OP_W'(OP_SUBI): acc_next = acc_reg - imm;
                        OP_W'(OP_OUT): begin
                            out_next       = acc_reg;
                            out_valid_next = 1'b1;
                        end
                        OP_W'(OP_JMP):  pc_next = target;
                        OP_W'(OP_BNZ):  if (acc_reg != '0) pc_next = target;
                        default:        illegal_next = 1'b1;
                    endcase
                end
            end
            S_HALT: ;
            default: state_next = S_IDLE;
        endcase
    end

    assign imem_req  = (state_reg == S_FETCH);
    assign imem_addr = pc_reg;
    assign pc        = pc_reg;
    assign out       = out_reg;
    assign out_valid = out_valid_reg;
    assign halted    = (state_reg == S_HALT);
    assign illegal   = illegal_reg;

endmodule
